// File: rtl/mux_merge_arbiter_if.sv
// mux_merge_arbiter_if
// Handshake bundle between the two input-buffer channels, the merge arbiter and the
// output link of one router output port.
//   in0_* / in1_* : flit payload, tail flag, valid (source -> arbiter), ready (arbiter -> source)
//   out_*         : registered winning flit, tail flag, source index, valid (arbiter -> link),
//                   out_ready (link -> arbiter)
// Modports:
//   master : the environment side (drives input flits and out_ready)
//   slave  : the arbiter side (drives ready signals and the output flit)
interface mux_merge_arbiter_if #(
  parameter int unsigned WIDTH = 11
);
  logic [WIDTH-1:0] in0_data;
  logic             in0_tail;
  logic             in0_valid;
  logic             in0_ready;

  logic [WIDTH-1:0] in1_data;
  logic             in1_tail;
  logic             in1_valid;
  logic             in1_ready;

  logic [WIDTH-1:0] out_data;
  logic             out_tail;
  logic             out_sel;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in0_data, in0_tail, in0_valid,
    input  in0_ready,
    output in1_data, in1_tail, in1_valid,
    input  in1_ready,
    input  out_data, out_tail, out_sel, out_valid,
    output out_ready
  );

  modport slave (
    input  in0_data, in0_tail, in0_valid,
    output in0_ready,
    input  in1_data, in1_tail, in1_valid,
    output in1_ready,
    output out_data, out_tail, out_sel, out_valid,
    input  out_ready
  );
endinterface

// File: rtl/mux_merge_arbiter.sv
// mux_merge_arbiter
// 2:1 round-robin merge arbiter for a router output port. Chooses which input channel feeds
// the shared output, produces the mux select, and registers the winning flit (1-cycle
// latency, 1 flit/cycle throughput).
// Ports:
//   clk  : single clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mux_merge_arbiter_if.slave - input channels 0/1 and the registered output link
//   busy : high while an output flit is held or a packet lock is active
// Configuration:
//   MUX_ARB_PKT_LOCK_EN defined   - a grant is held from a head flit until its tail flit,
//                                   so flits of different packets never interleave.
//   MUX_ARB_PKT_LOCK_EN undefined - flit-level round robin; tail is only forwarded.
module mux_merge_arbiter #(
  parameter int unsigned WIDTH = 11
) (
  input  logic               clk,
  input  logic               rst,
  mux_merge_arbiter_if.slave bus,
  output logic               busy
);

  typedef enum logic [1:0] {
    StUnlocked = 2'd0,
    StLock0    = 2'd1,
    StLock1    = 2'd2
  } state_e;

  state_e           state_q;
  logic             rr_ptr_q;  // preferred input when both are valid
  logic [WIDTH-1:0] out_data_q;
  logic             out_tail_q;
  logic             out_sel_q;
  logic             out_valid_q;

  logic             slot_free;
  logic             winner;
  logic             ready0;
  logic             ready1;
  logic             xfer;
  logic [WIDTH-1:0] win_data;
  logic             win_tail;

  // The output register can take a new flit when empty or being drained this cycle.
  assign slot_free = !out_valid_q || bus.out_ready;

  // Grant decode. Depends only on state, pointer, valids and output occupancy, never on data.
  always_comb begin
    winner = rr_ptr_q;
    ready0 = 1'b0;
    ready1 = 1'b0;
    unique case (state_q)
      StLock0: begin
        // Owner stays ready even while idle; the other side is shut out until the tail.
        winner = 1'b0;
        ready0 = slot_free;
      end
      StLock1: begin
        winner = 1'b1;
        ready1 = slot_free;
      end
      default: begin
        if (bus.in0_valid && bus.in1_valid) begin
          winner = rr_ptr_q;
        end else begin
          winner = bus.in1_valid;
        end
        ready0 = slot_free && bus.in0_valid && !winner;
        ready1 = slot_free && bus.in1_valid && winner;
      end
    endcase
    if (rst) begin
      ready0 = 1'b0;
      ready1 = 1'b0;
    end
  end

  assign xfer     = (bus.in0_valid && ready0) || (bus.in1_valid && ready1);
  assign win_data = winner ? bus.in1_data : bus.in0_data;
  assign win_tail = winner ? bus.in1_tail : bus.in0_tail;

  // Output register, arbitration pointer and lock state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StUnlocked;
      rr_ptr_q    <= 1'b0;
      out_data_q  <= '0;
      out_tail_q  <= 1'b0;
      out_sel_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (xfer) begin
        out_data_q  <= win_data;
        out_tail_q  <= win_tail;
        out_sel_q   <= winner;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (xfer) begin
`ifdef MUX_ARB_PKT_LOCK_EN
        unique case (state_q)
          StLock0, StLock1: begin
            if (win_tail) begin
              state_q  <= StUnlocked;
              rr_ptr_q <= ~winner;
            end
          end
          default: begin
            rr_ptr_q <= ~winner;
            // A head flit without tail opens a packet: hold the grant for its owner.
            if (!win_tail) begin
              state_q <= winner ? StLock1 : StLock0;
            end
          end
        endcase
`else
        rr_ptr_q <= ~winner;
`endif
      end
    end
  end

  assign bus.in0_ready = ready0;
  assign bus.in1_ready = ready1;
  assign bus.out_data  = out_data_q;
  assign bus.out_tail  = out_tail_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

  assign busy = out_valid_q || (state_q != StUnlocked);

endmodule

// File: tb/tb_mux_merge_arbiter.sv
`timescale 1ns/1ps
module tb_mux_merge_arbiter;
  localparam int unsigned W = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  mux_merge_arbiter_if #(.WIDTH(W)) bus ();

  mux_merge_arbiter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: output slot contents, whose turn it is, and which input owns a packet.
  bit           m_hold;
  logic [W-1:0] m_data;
  bit           m_tail;
  bit           m_sel;
  int           m_turn;
  int           m_owner;   // -1: no packet in progress
  bit           er0, er1;  // expected ready for the currently driven inputs

  function automatic void model_ready(output bit r0, output bit r1);
    r0 = 1'b0;
    r1 = 1'b0;
    if (rst || (m_hold && !bus.out_ready)) return;
    if (m_owner == 0) r0 = 1'b1;
    else if (m_owner == 1) r1 = 1'b1;
    else if (bus.in0_valid && (!bus.in1_valid || m_turn == 0)) r0 = 1'b1;
    else if (bus.in1_valid) r1 = 1'b1;
  endfunction

  task automatic model_step();
    bit r0, r1;
    int g;
    model_ready(r0, r1);
    g = -1;
    if (bus.in0_valid && r0) g = 0;
    else if (bus.in1_valid && r1) g = 1;
    if (rst) begin
      m_hold = 0; m_data = '0; m_tail = 0; m_sel = 0; m_turn = 0; m_owner = -1;
    end else if (g >= 0) begin
      m_hold = 1;
      m_sel  = (g == 1);
      m_data = (g == 1) ? bus.in1_data : bus.in0_data;
      m_tail = (g == 1) ? bus.in1_tail : bus.in0_tail;
`ifdef MUX_ARB_PKT_LOCK_EN
      m_owner = m_tail ? -1 : g;
`endif
      m_turn = 1 - g;
    end else if (bus.out_ready) begin
      m_hold = 0;
    end
  endtask

  task automatic drive(input bit v0, input logic [W-1:0] d0, input bit t0,
                       input bit v1, input logic [W-1:0] d1, input bit t1, input bit ordy);
    bus.in0_valid = v0; bus.in0_data = d0; bus.in0_tail = t0;
    bus.in1_valid = v1; bus.in1_data = d1; bus.in1_tail = t1;
    bus.out_ready = ordy;
    #1;
    model_ready(er0, er1);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1, 11'h0A1, 1, 1, 11'h1B2, 1, 1);
      checks++;
      if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
        errors++;
        $display("FAIL reset_ready: got %b%b expected 00", bus.in0_ready, bus.in1_ready);
      end
      tick();
      checks++;
      if ({bus.out_valid, bus.out_tail, bus.out_sel, bus.out_data, busy} !== '0) begin
        errors++;
        $display("FAIL reset_out: got v%b t%b s%b d%h busy%b expected all zero",
                 bus.out_valid, bus.out_tail, bus.out_sel, bus.out_data, busy);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_contention();
    logic [W-1:0] ed;
    for (int i = 0; i < 6; i++) begin
      drive(1, 11'h0A1, 1, 1, 11'h1B2, 1, 1);
      checks++;
      if ({bus.in0_ready, bus.in1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contention_ready[%0d]: got %b%b", i, bus.in0_ready, bus.in1_ready);
      end
      tick();
      ed = (i % 2 == 0) ? 11'h0A1 : 11'h1B2;
      checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, (i % 2 == 1), ed}) begin
        errors++;
        $display("FAIL contention_out[%0d]: got v%b s%b d%h expected v1 s%0d d%h",
                 i, bus.out_valid, bus.out_sel, bus.out_data, i % 2, ed);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      drive(1, 11'h0A1, 1, 1, 11'h1B2, 1, 0);
      checks++;
      if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b%b expected 00", i, bus.in0_ready, bus.in1_ready);
      end
      tick();
      checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 1'b1, 11'h1B2}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v%b s%b d%h expected v1 s1 d1b2",
                 i, bus.out_valid, bus.out_sel, bus.out_data);
      end
    end
    drive(1, 11'h0A1, 1, 1, 11'h1B2, 1, 1);
    checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release_ready: got %b%b expected 10", bus.in0_ready, bus.in1_ready);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 1'b0, 11'h0A1}) begin
      errors++;
      $display("FAIL bp_release_out: got v%b s%b d%h expected v1 s0 d0a1",
               bus.out_valid, bus.out_sel, bus.out_data);
    end
  endtask

  task automatic test_lock();
    logic [W-1:0] obs[$];
    logic [W-1:0] exp_seq[6];
    int idx;
`ifdef MUX_ARB_PKT_LOCK_EN
    exp_seq = '{11'h001, 11'h002, 11'h003, 11'h1B2, 11'h1B2, 11'h1B2};
`else
    exp_seq = '{11'h001, 11'h1B2, 11'h002, 11'h1B2, 11'h003, 11'h1B2};
`endif
    rst = 1'b1;
    drive(0, '0, 0, 0, '0, 0, 1);
    tick();
    rst = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      drive(idx < 3, W'(idx + 1), idx == 2, 1, 11'h1B2, 1, 1);
      checks++;
      if ({bus.in0_ready, bus.in1_ready} !== {er0, er1}) begin
        errors++;
        $display("FAIL lock_ready[%0d]: got %b%b expected %b%b",
                 c, bus.in0_ready, bus.in1_ready, er0, er1);
      end
      if (er0 && idx < 3) idx++;
      tick();
      if (bus.out_valid) obs.push_back(bus.out_data);
    end
    checks++;
    if (obs.size() < 6) begin
      errors++;
      $display("FAIL lock_count: got %0d flits expected at least 6", obs.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (obs[k] !== exp_seq[k]) begin
          errors++;
          $display("FAIL lock_order[%0d]: got %h expected %h", k, obs[k], exp_seq[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    rst = 1'b1;
    drive(0, '0, 0, 0, '0, 0, 1);
    tick();
    rst = 1'b0;
    drive(1, 11'h001, 0, 1, 11'h1B2, 1, 1);
    tick();
    rst = 1'b1;
    drive(1, 11'h002, 0, 1, 11'h1B2, 1, 1);
    checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_ready: got %b%b expected 00", bus.in0_ready, bus.in1_ready);
    end
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_out: got v%b busy%b expected 00", bus.out_valid, busy);
    end
    drive(0, 11'h002, 0, 1, 11'h1C4, 1, 1);
    checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL midrst_in1_ready: got %b%b expected 01", bus.in0_ready, bus.in1_ready);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 1'b1, 11'h1C4}) begin
      errors++;
      $display("FAIL midrst_in1_out: got v%b s%b d%h expected v1 s1 d1c4",
               bus.out_valid, bus.out_sel, bus.out_data);
    end
  endtask

  task automatic test_idle_fairness();
    drive(0, '0, 0, 0, '0, 0, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, '0, 0, 1, W'(11'h100 + k), 1, 1);
      checks++;
      if ({bus.in0_ready, bus.in1_ready} !== 2'b01) begin
        errors++;
        $display("FAIL idle_ready[%0d]: got %b%b expected 01", k, bus.in0_ready, bus.in1_ready);
      end
      tick();
      checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 1'b1, W'(11'h100 + k)}) begin
        errors++;
        $display("FAIL idle_out[%0d]: got v%b s%b d%h expected v1 s1 d%h",
                 k, bus.out_valid, bus.out_sel, bus.out_data, W'(11'h100 + k));
      end
    end
    // Pointer must now favour input 0.
    drive(1, 11'h055, 1, 1, 11'h1AA, 1, 1);
    checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL idle_rrptr: got %b%b expected 10", bus.in0_ready, bus.in1_ready);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] rd0, rd1;
    for (int c = 0; c < 600; c++) begin
      rd0 = W'($urandom);
      rd1 = W'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 9) < 7, rd0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) < 7, rd1, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0);
      checks++;
      if ({bus.in0_ready, bus.in1_ready} !== {er0, er1}) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b%b expected %b%b",
                 c, bus.in0_ready, bus.in1_ready, er0, er1);
      end
      tick();
      checks++;
      if ({bus.out_valid, bus.out_tail, bus.out_sel, bus.out_data} !==
          {m_hold, m_tail, m_sel, m_data}) begin
        errors++;
        $display("FAIL rand_out[%0d]: got v%b t%b s%b d%h expected v%b t%b s%b d%h", c,
                 bus.out_valid, bus.out_tail, bus.out_sel, bus.out_data,
                 m_hold, m_tail, m_sel, m_data);
      end
      checks++;
      if (busy !== (m_hold || m_owner != -1)) begin
        errors++;
        $display("FAIL rand_busy[%0d]: got %b expected %b", c, busy, m_hold || m_owner != -1);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_hold = 0; m_data = '0; m_tail = 0; m_sel = 0; m_turn = 0; m_owner = -1;
    bus.in0_valid = 0; bus.in0_data = '0; bus.in0_tail = 0;
    bus.in1_valid = 0; bus.in1_data = '0; bus.in1_tail = 0;
    bus.out_ready = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_contention();
    test_backpressure();
    test_lock();
    test_reset_mid_packet();
    test_idle_fairness();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
